// File: rtl/pkt_rx_drain.sv
// Receive-side drain for the MAC packet interface: pulls frames, buffers
// them in a 4-entry FIFO, and reports per-frame length/status/counters.
//
// Ports:
//   clk_156m25, reset_156m25 : core clock, async active-high reset
//   pkt_rx_*                 : MAC rx interface (ren out, rest in)
//   out_*                    : downstream valid/ready word stream
//   frame_done/len/status    : per-frame report, {oversize,protocol,mac_err}
//   frame_cnt, err_cnt       : saturating frame / errored-frame counters
module pkt_rx_drain #(
  parameter int MAX_FRAME_BYTES = 9600,
  parameter int CNT_W = 32
) (
  input  logic             clk_156m25,
  input  logic             reset_156m25,
  input  logic             pkt_rx_avail,
  output logic             pkt_rx_ren,
  input  logic             pkt_rx_val,
  input  logic [63:0]      pkt_rx_data,
  input  logic             pkt_rx_sop,
  input  logic             pkt_rx_eop,
  input  logic [2:0]       pkt_rx_mod,
  input  logic             pkt_rx_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic             out_sop,
  output logic             out_eop,
  output logic [2:0]       out_mod,
  output logic             frame_done,
  output logic [13:0]      frame_len,
  output logic [2:0]       frame_status,
  output logic [CNT_W-1:0] frame_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic {IDLE, READ} state_t;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
  } word_t;

  typedef struct packed {
    logic [13:0] len;
    logic [2:0]  st;
  } rep_t;

  localparam logic [13:0] LEN_MAX = 14'h3fff;

  state_t      state, state_n;
  word_t       mem [4];
  word_t       head;
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  occ, occ_n;
  logic        push, pop, ren_n;
  logic        started, started_n;
  logic        proto, proto_n;
  logic [13:0] bcnt, bcnt_n;
  logic        stray, cur_start, cur_proto, first_bad;
  logic [13:0] cur_bcnt, len_eop;
  logic [3:0]  mb;
  logic        ev_a, ev_b;
  rep_t        rep_a, rep_b;
  logic        pend_v, pend_v_n;
  rep_t        pend, pend_n;
  logic        emit;
  rep_t        emit_rep;

  function automatic logic [13:0] sat_add(
    input logic [13:0] a,
    input logic [3:0]  b
  );
    logic [14:0] s;
    s = {1'b0, a} + {11'd0, b};
    return s[14] ? LEN_MAX : s[13:0];
  endfunction

  function automatic logic over(input logic [13:0] l);
    return 32'(l) > MAX_FRAME_BYTES;
  endfunction

  assign head      = mem[rd_ptr];
  assign out_valid = (occ != 3'd0);
  assign out_data  = out_valid ? head.data : 64'd0;
  assign out_sop   = out_valid & head.sop;
  assign out_eop   = out_valid & head.eop;
  assign out_mod   = out_valid ? head.mod : 3'd0;

  always_comb begin
    mb    = (pkt_rx_mod == 3'd0) ? 4'd8 : {1'b0, pkt_rx_mod};
    push  = pkt_rx_val && (state == READ || pkt_rx_sop);
    pop   = out_valid && out_ready;
    occ_n = occ + {2'b0, push} - {2'b0, pop};

    // A sop inside an open frame closes it and restarts accounting
    stray     = push && pkt_rx_sop && started;
    cur_bcnt  = stray ? 14'd0 : bcnt;
    cur_proto = stray ? 1'b0 : proto;
    cur_start = stray ? 1'b0 : started;
    first_bad = !cur_start && !pkt_rx_sop;
    len_eop   = sat_add(cur_bcnt, mb);

    ev_a      = 1'b0;
    ev_b      = 1'b0;
    rep_a     = '0;
    rep_b     = '0;
    started_n = started;
    proto_n   = proto;
    bcnt_n    = bcnt;

    if (pkt_rx_val && !push) begin
      ev_a     = 1'b1;
      rep_a.st = 3'b010;
    end
    if (stray) begin
      ev_a      = 1'b1;
      rep_a.len = bcnt;
      rep_a.st  = {over(bcnt), 2'b10};
    end
    if (push) begin
      if (pkt_rx_eop) begin
        ev_b      = 1'b1;
        rep_b.len = len_eop;
        rep_b.st  = {over(len_eop), cur_proto | first_bad,
                     pkt_rx_err};
        started_n = 1'b0;
        proto_n   = 1'b0;
        bcnt_n    = 14'd0;
      end else begin
        started_n = 1'b1;
        proto_n   = cur_proto | first_bad;
        bcnt_n    = sat_add(cur_bcnt, 4'd8);
      end
    end

    state_n = state;
    unique case (1'b1)
      push && pkt_rx_eop: state_n = IDLE;
      push && !pkt_rx_eop: state_n = READ;
      default: begin
        if (state == IDLE && pkt_rx_avail && occ != 3'd4)
          state_n = READ;
      end
    endcase

    // Reads in flight are counted so the buffer can never overflow
    ren_n = (state_n == READ || pkt_rx_avail) &&
            ((occ_n + {2'b0, pkt_rx_ren}) <= 3'd2);

    // A stray sop that is also eop closes two frames at once;
    // the second report waits one cycle in pend
    emit     = 1'b0;
    emit_rep = '0;
    pend_v_n = pend_v;
    pend_n   = pend;
    if (pend_v) begin
      emit     = 1'b1;
      emit_rep = pend;
      pend_v_n = ev_a | ev_b;
      pend_n   = ev_a ? rep_a : rep_b;
    end else if (ev_a) begin
      emit     = 1'b1;
      emit_rep = rep_a;
      pend_v_n = ev_b;
      pend_n   = rep_b;
    end else if (ev_b) begin
      emit     = 1'b1;
      emit_rep = rep_b;
    end
  end

  always_ff @(posedge clk_156m25 or posedge reset_156m25) begin
    if (reset_156m25) begin
      state        <= IDLE;
      wr_ptr       <= 2'd0;
      rd_ptr       <= 2'd0;
      occ          <= 3'd0;
      pkt_rx_ren   <= 1'b0;
      started      <= 1'b0;
      proto        <= 1'b0;
      bcnt         <= 14'd0;
      pend_v       <= 1'b0;
      pend         <= '0;
      frame_done   <= 1'b0;
      frame_len    <= 14'd0;
      frame_status <= 3'd0;
      frame_cnt    <= '0;
      err_cnt      <= '0;
    end else begin
      state      <= state_n;
      occ        <= occ_n;
      pkt_rx_ren <= ren_n;
      started    <= started_n;
      proto      <= proto_n;
      bcnt       <= bcnt_n;
      pend_v     <= pend_v_n;
      pend       <= pend_n;
      frame_done <= emit;
      if (push)
        wr_ptr <= wr_ptr + 2'd1;
      if (pop)
        rd_ptr <= rd_ptr + 2'd1;
      if (emit) begin
        frame_len    <= emit_rep.len;
        frame_status <= emit_rep.st;
        if (frame_cnt != '1)
          frame_cnt <= frame_cnt + CNT_W'(1);
        if (emit_rep.st != 3'd0 && err_cnt != '1)
          err_cnt <= err_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_156m25) begin
    if (push)
      mem[wr_ptr] <= '{data: pkt_rx_data, sop: pkt_rx_sop,
                       eop: pkt_rx_eop, mod: pkt_rx_mod};
  end

endmodule

// File: tb/tb_pkt_rx_drain.sv
// Bench for pkt_rx_drain: MAC word-queue model, word scoreboard and
// frame-report model derived from frame descriptors.
module tb_pkt_rx_drain;

  localparam int MAXB = 9600;

  logic        clk = 1'b0;
  logic        rst;
  logic        avail, ren, val, sop, eop, err;
  logic [63:0] data;
  logic [2:0]  mod;
  logic        o_valid, o_ready, o_sop, o_eop;
  logic [63:0] o_data;
  logic [2:0]  o_mod;
  logic        done;
  logic [13:0] flen;
  logic [2:0]  fst;
  logic [31:0] fcnt, ecnt;

  always #5 clk = ~clk;

  pkt_rx_drain #(.MAX_FRAME_BYTES(MAXB), .CNT_W(32)) dut (
    .clk_156m25(clk), .reset_156m25(rst),
    .pkt_rx_avail(avail), .pkt_rx_ren(ren),
    .pkt_rx_val(val), .pkt_rx_data(data),
    .pkt_rx_sop(sop), .pkt_rx_eop(eop),
    .pkt_rx_mod(mod), .pkt_rx_err(err),
    .out_valid(o_valid), .out_ready(o_ready),
    .out_data(o_data), .out_sop(o_sop),
    .out_eop(o_eop), .out_mod(o_mod),
    .frame_done(done), .frame_len(flen),
    .frame_status(fst), .frame_cnt(fcnt),
    .err_cnt(ecnt)
  );

  typedef struct {
    logic [63:0] d;
    logic        sop;
    logic        eop;
    logic [2:0]  mod;
    logic        err;
  } w_t;

  typedef struct {
    int len;
    int st;
  } r_t;

  w_t mac_q[$];
  w_t exp_q[$];
  r_t rep_q[$];
  int n_chk = 0;
  int n_pass = 0;
  int mdl_fc = 0;
  int mdl_ec = 0;
  int rdy_mode = 0;
  int bubbles = 0;
  int n_pres = 0;
  bit mid = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", tag, got, exp);
  endtask

  task automatic add_frame(input int nw, input int m,
                           input bit e, input bit rep);
    w_t w;
    r_t r;
    int l;
    for (int i = 0; i < nw; i++) begin
      w.d   = {$urandom, $urandom};
      w.sop = (i == 0);
      w.eop = (i == nw - 1);
      w.mod = w.eop ? m[2:0] : 3'd0;
      w.err = w.eop && e;
      mac_q.push_back(w);
    end
    l = 8 * (nw - 1) + ((m == 0) ? 8 : m);
    if (l > 16383) l = 16383;
    r.len = l;
    r.st  = (l > MAXB ? 4 : 0) + (e ? 1 : 0);
    if (rep) rep_q.push_back(r);
  endtask

  // Frame cut short by a following sop: protocol, len through last word
  task automatic add_partial(input int nw);
    w_t w;
    r_t r;
    for (int i = 0; i < nw; i++) begin
      w.d   = {$urandom, $urandom};
      w.sop = (i == 0);
      w.eop = 1'b0;
      w.mod = 3'd0;
      w.err = 1'b0;
      mac_q.push_back(w);
    end
    r.len = 8 * nw;
    r.st  = 2 + (r.len > MAXB ? 4 : 0);
    rep_q.push_back(r);
  endtask

  initial begin : env
    w_t pres, w;
    r_t r;
    bit pres_v, ren_s;
    pres_v = 0;
    ren_s  = 0;
    avail = 0; val = 0; sop = 0; eop = 0; err = 0;
    data = '0; mod = '0; o_ready = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        chk("rst_ren", ren, 0);
        chk("rst_oval", o_valid, 0);
        chk("rst_done", done, 0);
        exp_q.delete();
        pres_v = 0;
        while (mid && mac_q.size() > 0) begin
          mid = !mac_q[0].eop;
          void'(mac_q.pop_front());
        end
        mid = 0;
        mdl_fc = 0;
        mdl_ec = 0;
        ren_s = 0;
      end else begin
        chk("oval", o_valid, exp_q.size() > 0);
        chk("occ_le4", exp_q.size() <= 4, 1);
        if (o_valid && o_ready) begin
          if (exp_q.size() == 0) chk("extra_word", 1, 0);
          else begin
            w = exp_q.pop_front();
            chk("data", o_data, w.d);
            chk("sop", o_sop, w.sop);
            chk("eop", o_eop, w.eop);
            chk("mod", o_mod, w.mod);
          end
        end
        if (pres_v) exp_q.push_back(pres);
        if (done) begin
          mdl_fc++;
          if (rep_q.size() == 0) chk("extra_done", 1, 0);
          else begin
            r = rep_q.pop_front();
            chk("len", flen, r.len);
            chk("status", fst, r.st);
            if (r.st != 0) mdl_ec++;
          end
          chk("frame_cnt", fcnt, mdl_fc);
          chk("err_cnt", ecnt, mdl_ec);
        end
        ren_s = ren;
      end
      @(posedge clk);
      #1;
      pres_v = 0;
      if (!rst && ren_s && mac_q.size() > 0) begin
        pres   = mac_q.pop_front();
        pres_v = 1;
        n_pres++;
        mid  = !pres.eop;
        val  = 1;
        data = pres.d;
        sop  = pres.sop;
        eop  = pres.eop;
        mod  = pres.mod;
        err  = pres.err;
      end else begin
        if (!rst && mid && rdy_mode == 0) bubbles++;
        val = 0; sop = 0; eop = 0; err = 0; mod = 0;
        data = '0;
      end
      avail = (mac_q.size() > 0);
      case (rdy_mode)
        0: o_ready = 1;
        1: o_ready = ~o_ready;
        default: o_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1;
    @(posedge clk);
    #2 rst = 0;
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((mac_q.size() != 0 || exp_q.size() != 0 ||
            rep_q.size() != 0) && k < budget) begin
      @(posedge clk);
      #3;
      k++;
    end
    chk("drain_timeout", k < budget, 1);
    repeat (3) @(posedge clk);
    #3;
  endtask

  initial begin : main
    int k;
    rst = 1;
    repeat (2) @(posedge clk);
    #2;
    chk("r_ren", ren, 0);
    chk("r_oval", o_valid, 0);
    chk("r_odata", o_data, 0);
    chk("r_osop", o_sop, 0);
    chk("r_oeop", o_eop, 0);
    chk("r_omod", o_mod, 0);
    chk("r_done", done, 0);
    chk("r_len", flen, 0);
    chk("r_st", fst, 0);
    chk("r_fcnt", fcnt, 0);
    chk("r_ecnt", ecnt, 0);
    rst = 0;

    rdy_mode = 0;
    bubbles = 0;
    add_frame(8, 0, 0, 1);
    drain(200);
    chk("t1_bubbles", bubbles, 0);
    chk("t1_len", flen, 64);
    chk("t1_fcnt", fcnt, 1);

    do_reset();
    rdy_mode = 1;
    add_frame(8, 5, 0, 1);
    drain(200);
    chk("t2_len", flen, 61);

    do_reset();
    rdy_mode = 2;
    add_frame(8, 0, 1, 1);
    drain(200);
    chk("t3_st", fst, 1);
    chk("t3_ecnt", ecnt, 1);

    do_reset();
    rdy_mode = 0;
    bubbles = 0;
    add_frame(1201, 0, 0, 1);
    drain(3000);
    chk("t4_st", fst, 4);
    chk("t4_len", flen, 9608);
    chk("t4_bubbles", bubbles, 0);

    do_reset();
    add_partial(3);
    add_frame(2, 0, 0, 1);
    drain(200);
    chk("t5_fcnt", fcnt, 2);
    chk("t5_ecnt", ecnt, 1);

    do_reset();
    n_pres = 0;
    add_frame(8, 0, 0, 0);
    k = 0;
    while (n_pres < 4 && k < 200) begin
      @(posedge clk);
      #2;
      k++;
    end
    chk("t6_wait", k < 200, 1);
    rst = 1;
    @(posedge clk);
    #2 rst = 0;
    add_frame(8, 0, 0, 1);
    drain(200);
    chk("t6_len", flen, 64);
    chk("t6_fcnt", fcnt, 1);

    do_reset();
    rdy_mode = 2;
    for (int i = 0; i < 30; i++)
      add_frame(int'($urandom_range(1, 20)),
                int'($urandom_range(0, 7)),
                ($urandom_range(0, 3) == 0), 1);
    drain(5000);
    chk("t7_fcnt", fcnt, mdl_fc);
    chk("t7_ecnt", ecnt, mdl_ec);
    chk("t7_n", mdl_fc, 30);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
